// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory arbiter: word width, default
// parameters and the arbiter FSM state encoding.
package im_pkg;

  localparam int IM_WORD_W    = 32;
  localparam int IM_ADDR_W    = 10;
  localparam int IM_MAX_BURST = 8;
  localparam int BURST_CNT_W  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    OWN0 = ST_OWN0,
    OWN1 = ST_OWN1
  } arb_state_t;

endpackage

// File: rtl/im_rr_pick.sv
// Two-way round-robin chooser: picks the requesting port, and on a tie the
// port that was not granted last.
module im_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic sel,
  output logic any
);

  always_comb begin
    any = req0 | req1;
    if (req0 && req1) sel = ~rr_last;
    else              sel = req1;
  end

endmodule

// File: rtl/im_arbiter.sv
// Two-port arbiter in front of the combinational-read instruction memory:
// round-robin with optional locked bursts capped at MAX_BURST, registered reads.
module im_arbiter
  import im_pkg::*;
#(
  parameter int ADDR_W    = IM_ADDR_W,
  parameter int MAX_BURST = IM_MAX_BURST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic                 lock0,
  output logic                 gnt0,
  output logic                 rvalid0,
  output logic [IM_WORD_W-1:0] rdata0,
  output logic                 rerr0,
  input  logic                 req1,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic                 lock1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [IM_WORD_W-1:0] rdata1,
  output logic                 rerr1,
  output logic [ADDR_W-1:0]    im_addr,
  input  logic [IM_WORD_W-1:0] im_dout
);

  arb_state_t             state, state_nxt;
  logic                   rr_last, rr_nxt;
  logic [BURST_CNT_W-1:0] burst_cnt, cnt_nxt;
  logic [ADDR_W-1:0]      im_addr_q;

  logic gnt_any, gnt_sel;
  logic pick_req0, pick_req1, pick_sel, pick_any;
  logic own, own_req, own_lock, sel_lock, cap_hit;
  logic [ADDR_W-1:0] gnt_addr;

  // While a port owns the memory the chooser only sees the other port, so its
  // output is exactly the hand-off candidate.
  assign pick_req0 = req0 && (state != OWN0);
  assign pick_req1 = req1 && (state != OWN1);

  im_rr_pick u_pick (
    .req0    (pick_req0),
    .req1    (pick_req1),
    .rr_last (rr_last),
    .sel     (pick_sel),
    .any     (pick_any)
  );

  assign own      = (state == OWN1);
  assign own_req  = own ? req1  : req0;
  assign own_lock = own ? lock1 : lock0;
  assign sel_lock = pick_sel ? lock1 : lock0;
  assign cap_hit  = (burst_cnt >= BURST_CNT_W'(MAX_BURST));

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_last;
    cnt_nxt   = burst_cnt;
    gnt_any   = 1'b0;
    gnt_sel   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_any = 1'b1;
          gnt_sel = pick_sel;
          rr_nxt  = pick_sel;
          if (sel_lock) begin
            state_nxt = pick_sel ? OWN1 : OWN0;
            cnt_nxt   = BURST_CNT_W'(1);
          end
        end
      end
      OWN0, OWN1: begin
        if (cap_hit && pick_any) begin
          gnt_any   = 1'b1;
          gnt_sel   = pick_sel;
          rr_nxt    = pick_sel;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (own_req) begin
          gnt_any = 1'b1;
          gnt_sel = own;
          rr_nxt  = own;
          cnt_nxt = (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;
          if (!own_lock) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else if (own_lock) begin
          // Owner is pausing but keeps the lock: lend the slot, keep the burst.
          gnt_any = pick_any;
          gnt_sel = pick_sel;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign gnt0 = gnt_any && !gnt_sel && !rst;
  assign gnt1 = gnt_any &&  gnt_sel && !rst;

  assign gnt_addr = gnt_sel ? addr1 : addr0;
  assign im_addr  = (gnt0 || gnt1) ? {gnt_addr[ADDR_W-1:2], 2'b00} : im_addr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
      im_addr_q <= '0;
      rvalid0   <= 1'b0;
      rdata0    <= '0;
      rerr0     <= 1'b0;
      rvalid1   <= 1'b0;
      rdata1    <= '0;
      rerr1     <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_last   <= rr_nxt;
      burst_cnt <= cnt_nxt;
      im_addr_q <= im_addr;
      rvalid0   <= gnt0;
      rvalid1   <= gnt1;
      if (gnt0) begin
        rdata0 <= im_dout;
        rerr0  <= (addr0[1:0] != 2'b00);
      end
      if (gnt1) begin
        rdata1 <= im_dout;
        rerr1  <= (addr1[1:0] != 2'b00);
      end
    end
  end

endmodule
